// File: rtl/icache_refill_ctrl.sv
// Icache lookup/refill controller sitting in front of the tag FIFO.
// Serves CPU line fetches (compare, refill on miss, tag commit, re-lookup),
// single-line invalidates and whole-cache flushes. Outputs are decoded from the
// current state plus live inputs, so a hit is reported in the cycle after accept.
module icache_refill_ctrl #(
    parameter int DP    = 4,
    parameter int TAG_W = 14,
    parameter int BEATS = 4
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  cpu_req,
    input  logic [TAG_W-1:0]                      cpu_tag,
    output logic                                  cpu_rdy,
    output logic                                  cpu_hit,
    output logic [$clog2(DP)-1:0]                 cpu_hindex,
    output logic                                  cpu_err,
    input  logic                                  inv_req,
    input  logic [TAG_W-1:0]                      inv_tag,
    output logic                                  inv_done,
    input  logic                                  flush_req,
    output logic                                  flush_done,
    output logic [TAG_W-1:0]                      tag_cmp_data,
    input  logic [DP-1:0]                         tag_hit,
    input  logic [$clog2(DP)-1:0]                 tag_hindex,
    input  logic [$clog2(DP)-1:0]                 tag_wptr,
    output logic                                  tag_wr,
    output logic                                  tag_uwr,
    output logic [$clog2(DP)-1:0]                 tag_uptr,
    output logic [TAG_W:0]                        tag_wdata,
    output logic                                  tag_flush,
    output logic                                  mem_req,
    output logic [TAG_W-1:0]                      mem_addr,
    input  logic                                  mem_ack,
    input  logic                                  mem_rvalid,
    input  logic                                  mem_rerr,
    output logic                                  line_we,
    output logic [$clog2(DP)+$clog2(BEATS)-1:0]   line_waddr
);

    localparam int AW = $clog2(DP);
    localparam int BW = $clog2(BEATS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_REFILL_REQ,
        S_REFILL_DATA,
        S_TAG_WR,
        S_INV
    } state_t;

    state_t            state;
    logic [TAG_W-1:0]  tag_q;     // tag under lookup / refill / invalidate
    logic [AW-1:0]     victim_q;  // FIFO slot being refilled
    logic [BW-1:0]     beat_q;    // next beat to write into the line RAM

    wire any_hit  = |tag_hit;
    wire last_beat = (beat_q == BW'(BEATS - 1));

    // State and latched operands; flush never leaves IDLE, invalidate beats fetch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            tag_q    <= '0;
            victim_q <= '0;
            beat_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (flush_req) begin
                        state <= S_IDLE;
                    end else if (inv_req) begin
                        tag_q <= inv_tag;
                        state <= S_INV;
                    end else if (cpu_req) begin
                        tag_q <= cpu_tag;
                        state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (any_hit) begin
                        state <= S_IDLE;
                    end else begin
                        victim_q <= tag_wptr;
                        beat_q   <= '0;
                        state    <= S_REFILL_REQ;
                    end
                end
                S_REFILL_REQ: begin
                    // A beat arriving together with the ack is not ours yet.
                    if (mem_ack) state <= S_REFILL_DATA;
                end
                S_REFILL_DATA: begin
                    if (mem_rvalid) begin
                        if (mem_rerr) begin
                            state <= S_IDLE;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                            if (last_beat) state <= S_TAG_WR;
                        end
                    end
                end
                S_TAG_WR: state <= S_LOOKUP;
                S_INV:    state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    // Output decode: strobes are qualified by state and the live handshakes.
    always_comb begin
        cpu_rdy      = 1'b0;
        cpu_hit      = 1'b0;
        cpu_hindex   = '0;
        cpu_err      = 1'b0;
        inv_done     = 1'b0;
        flush_done   = 1'b0;
        tag_cmp_data = tag_q;
        tag_wr       = 1'b0;
        tag_uwr      = 1'b0;
        tag_uptr     = '0;
        tag_wdata    = '0;
        tag_flush    = 1'b0;
        mem_req      = 1'b0;
        mem_addr     = '0;
        line_we      = 1'b0;
        line_waddr   = '0;
        case (state)
            S_IDLE: begin
                cpu_rdy = !flush_req && !inv_req;
                if (flush_req) begin
                    tag_flush  = 1'b1;
                    flush_done = 1'b1;
                end
            end
            S_LOOKUP: begin
                if (any_hit) begin
                    cpu_hit    = 1'b1;
                    cpu_hindex = tag_hindex;
                end
            end
            S_REFILL_REQ: begin
                mem_req  = 1'b1;
                mem_addr = tag_q;
            end
            S_REFILL_DATA: begin
                if (mem_rvalid) begin
                    if (mem_rerr) begin
                        cpu_err = 1'b1;
                    end else begin
                        line_we    = 1'b1;
                        line_waddr = {victim_q, beat_q};
                    end
                end
            end
            S_TAG_WR: begin
                tag_wr    = 1'b1;
                tag_wdata = {1'b1, tag_q};
            end
            S_INV: begin
                inv_done = 1'b1;
                if (any_hit) begin
                    tag_uwr   = 1'b1;
                    tag_uptr  = tag_hindex;
                    tag_wdata = {1'b0, tag_q};
                end
            end
            default: ;
        endcase
    end

endmodule
